// File: rtl/spi_byte_tx.sv
// spi_byte_tx: single-byte SPI master transmitter, mode 0 (spi_sck idles low, data is
// sampled by the slave on the rising edge and advanced on the falling edge).
//
// A byte is requested with sendEnable/data and accepted only from IDLE. The byte then
// runs SETUP (chip select asserted, first bit on spi_mosi), SHIFT (8 spi_sck pulses) and
// DONE (spi_sck low, then chip select released and held released before returning to
// IDLE). Every output comes straight from a register.
//
// Parameters:
//   CLK_DIV     baseClk cycles per spi_sck half-period, 1..255
// Ports:
//   baseClk     clock, all logic on its rising edge
//   hard_Clr    synchronous active-high reset, overrides every other input
//   data        byte to transmit, sampled only in IDLE while sendEnable is high
//   sendEnable  transmit request, held by upstream until sendBusy is seen high
//   sendBusy    high from acceptance until the byte is fully retired
//   spi_sck     SPI clock
//   spi_cs_n    active-low chip select, low only for the duration of a byte
//   spi_mosi    serial data out
// Build option:
//   SPI_LSB_FIRST_EN  when defined, data[0] is sent first; otherwise data[7] is sent first.
//                     Only the bit order changes.

module spi_byte_tx #(
    parameter int unsigned CLK_DIV = 4
) (
    input  logic       baseClk,
    input  logic       hard_Clr,
    input  logic [7:0] data,
    input  logic       sendEnable,
    output logic       sendBusy,
    output logic       spi_sck,
    output logic       spi_cs_n,
    output logic       spi_mosi
);

    typedef enum logic [1:0] {
        StIdle,
        StSetup,
        StShift,
        StDone
    } state_e;

    // The half-period counter runs from DivLast down to zero, so an expiry every
    // CLK_DIV cycles also works for CLK_DIV = 1 (counter stays at zero).
    localparam logic [7:0] DivLast = 8'(CLK_DIV - 1);

    state_e     state_q, state_d;
    logic [7:0] cnt_q, cnt_d;
    logic [2:0] bit_q, bit_d;
    logic [7:0] shreg_q, shreg_d;
    logic       busy_q, busy_d;
    logic       sck_q, sck_d;
    logic       cs_n_q, cs_n_d;
    logic       mosi_q, mosi_d;
    logic [7:0] shreg_rot;

    // The shift register rotates rather than shifts; the bit on the wire is always the
    // one at FirstBit.
`ifdef SPI_LSB_FIRST_EN
    localparam int unsigned FirstBit = 0;
    assign shreg_rot = {shreg_q[0], shreg_q[7:1]};
`else
    localparam int unsigned FirstBit = 7;
    assign shreg_rot = {shreg_q[6:0], shreg_q[7]};
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        shreg_d = shreg_q;
        busy_d  = busy_q;
        sck_d   = sck_q;
        cs_n_d  = cs_n_q;
        mosi_d  = mosi_q;

        unique case (state_q)
            StIdle: begin
                if (sendEnable) begin
                    shreg_d = data;
                    mosi_d  = data[FirstBit];
                    busy_d  = 1'b1;
                    cs_n_d  = 1'b0;
                    cnt_d   = DivLast;
                    bit_d   = '0;
                    state_d = StSetup;
                end
            end

            StSetup: begin
                if (cnt_q == '0) begin
                    sck_d   = 1'b1;
                    cnt_d   = DivLast;
                    state_d = StShift;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end

            StShift: begin
                if (cnt_q == '0) begin
                    cnt_d = DivLast;
                    sck_d = ~sck_q;
                    // sck_q high here means this expiry is a falling edge.
                    if (sck_q) begin
                        if (bit_q == 3'd7) begin
                            state_d = StDone;
                        end else begin
                            bit_d   = bit_q + 3'd1;
                            shreg_d = shreg_rot;
                            mosi_d  = shreg_rot[FirstBit];
                        end
                    end
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end

            StDone: begin
                // Two timed phases: spi_sck low with chip select still asserted, then chip
                // select released for CLK_DIV cycles so back-to-back bytes keep a gap.
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - 8'd1;
                end else if (!cs_n_q) begin
                    cs_n_d = 1'b1;
                    cnt_d  = DivLast;
                end else if (!sendEnable) begin
                    // Holding here while the request stays high stops it starting a second byte.
                    busy_d  = 1'b0;
                    mosi_d  = 1'b0;
                    state_d = StIdle;
                end
            end
        endcase
    end

    always_ff @(posedge baseClk) begin
        if (hard_Clr) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            bit_q   <= '0;
            shreg_q <= '0;
            busy_q  <= 1'b0;
            sck_q   <= 1'b0;
            cs_n_q  <= 1'b1;
            mosi_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shreg_q <= shreg_d;
            busy_q  <= busy_d;
            sck_q   <= sck_d;
            cs_n_q  <= cs_n_d;
            mosi_q  <= mosi_d;
        end
    end

    assign sendBusy = busy_q;
    assign spi_sck  = sck_q;
    assign spi_cs_n = cs_n_q;
    assign spi_mosi = mosi_q;

endmodule

// File: tb/tb_spi_byte_tx.sv
// Bench for spi_byte_tx: two instances (CLK_DIV = 4 and CLK_DIV = 1) driven through the
// sendEnable/sendBusy handshake. The stimulus process pushes the bit pattern each request
// should put on the wire; a separate monitor acts as the SPI slave, times every spi_sck
// rising edge against chip select, and pops/compares at each chip-select release.

module tb_spi_byte_tx;

    localparam int NumDut = 2;
    localparam int Div0   = 4;
    localparam int Div1   = 1;
`ifdef SPI_LSB_FIRST_EN
    localparam bit LsbFirst = 1'b1;
`else
    localparam bit LsbFirst = 1'b0;
`endif

    typedef struct packed {
        logic [7:0] pat;
        logic       aborted;
    } exp_t;

    logic       baseClk = 1'b0;
    logic [7:0] data_s [NumDut];
    logic       sen    [NumDut];
    logic       clr    [NumDut];
    logic       busy   [NumDut];
    logic       sck    [NumDut];
    logic       cs_n   [NumDut];
    logic       mosi   [NumDut];

    exp_t exp_q0[$];
    exp_t exp_q1[$];
    bit   done_req = 1'b0;
    int   checks   = 0;
    int   errors   = 0;

    always #5 baseClk = ~baseClk;

    spi_byte_tx #(.CLK_DIV(Div0)) u_dut_div4 (
        .baseClk    (baseClk),
        .hard_Clr   (clr[0]),
        .data       (data_s[0]),
        .sendEnable (sen[0]),
        .sendBusy   (busy[0]),
        .spi_sck    (sck[0]),
        .spi_cs_n   (cs_n[0]),
        .spi_mosi   (mosi[0])
    );

    spi_byte_tx #(.CLK_DIV(Div1)) u_dut_div1 (
        .baseClk    (baseClk),
        .hard_Clr   (clr[1]),
        .data       (data_s[1]),
        .sendEnable (sen[1]),
        .sendBusy   (busy[1]),
        .spi_sck    (sck[1]),
        .spi_cs_n   (cs_n[1]),
        .spi_mosi   (mosi[1])
    );

    function automatic int div_of(input int g);
        return (g == 0) ? Div0 : Div1;
    endfunction

    // Bits in wire order, packed first-sent in the MSB.
    function automatic logic [7:0] expect_pat(input logic [7:0] d);
        logic [7:0] p;
        p = '0;
        for (int i = 0; i < 8; i++) p = {p[6:0], (LsbFirst ? d[i] : d[7 - i])};
        return p;
    endfunction

    task automatic push_exp(input int g, input exp_t e);
        if (g == 0) exp_q0.push_back(e);
        else exp_q1.push_back(e);
    endtask

    task automatic chk(input bit ok, input string name, input int g, input int act,
                       input int req);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s dut%0d: got %0d, expected %0d (t=%0t)", name, g, act, req, $time);
        end
    endtask

    task automatic tick();
        @(posedge baseClk);
        #1;
    endtask

    // One request through the handshake. With hold set, sendEnable stays high until well
    // after chip select has been released.
    task automatic send(input int g, input logic [7:0] d, input bit hold);
        int   n;
        exp_t e;
        e.pat     = expect_pat(d);
        e.aborted = 1'b0;
        push_exp(g, e);
        data_s[g] = d;
        sen[g]    = 1'b1;
        n = 0;
        while (busy[g] !== 1'b1 && n < 8) begin
            tick();
            n++;
        end
        data_s[g] = 8'($urandom);
        if (hold) begin
            n = 0;
            while (cs_n[g] !== 1'b1 && n < 40 * div_of(g)) begin
                tick();
                n++;
            end
            repeat ($urandom_range(1, 6)) tick();
        end else begin
            repeat ($urandom_range(0, 2)) tick();
        end
        sen[g] = 1'b0;
        n = 0;
        while (busy[g] !== 1'b0 && n < 40 * div_of(g) + 10) begin
            tick();
            n++;
        end
        repeat ($urandom_range(0, 3)) tick();
    endtask

    // Start a byte and reset the instance right after its third spi_sck rising edge.
    task automatic send_abort(input int g, input logic [7:0] d);
        int   n;
        int   rises;
        logic prev;
        exp_t e;
        e.pat     = expect_pat(d);
        e.aborted = 1'b1;
        push_exp(g, e);
        data_s[g] = d;
        sen[g]    = 1'b1;
        n = 0;
        while (busy[g] !== 1'b1 && n < 8) begin
            tick();
            n++;
        end
        sen[g] = 1'b0;
        rises  = 0;
        prev   = sck[g];
        n      = 0;
        while (rises < 3 && n < 40 * div_of(g)) begin
            tick();
            if (sck[g] === 1'b1 && prev === 1'b0) rises++;
            prev = sck[g];
            n++;
        end
        clr[g] = 1'b1;
        tick();
        clr[g] = 1'b0;
        repeat (6 * div_of(g)) tick();
    endtask

    // Stimulus
    initial begin : stimulus
        logic [7:0] frame [5];
        frame = '{8'hFF, 8'h78, 8'h56, 8'h34, 8'h12};
        for (int g = 0; g < NumDut; g++) begin
            data_s[g] = '0;
            sen[g]    = 1'b0;
            clr[g]    = 1'b1;
        end
        repeat (3) tick();
        for (int g = 0; g < NumDut; g++) clr[g] = 1'b0;
        repeat (2) tick();

        send(0, 8'hA5, 1'b0);
        for (int i = 0; i < 5; i++) send(0, frame[i], 1'b0);
        send(0, 8'($urandom), 1'b1);
        send_abort(0, 8'h96);
        send(0, 8'h5A, 1'b0);
        send(0, 8'h01, 1'b0);
        for (int i = 0; i < 12; i++) send(0, 8'($urandom), ($urandom_range(0, 3) == 0));

        send(1, 8'h3C, 1'b0);
        send(1, 8'h01, 1'b1);
        send_abort(1, 8'hC3);
        send(1, 8'hE7, 1'b0);
        for (int i = 0; i < 15; i++) send(1, 8'($urandom), ($urandom_range(0, 3) == 0));

        repeat (5) tick();
        done_req = 1'b1;
    end

    // Monitor / SPI slave / scoreboard
    logic       sck_p   [NumDut] = '{1'b0, 1'b0};
    logic       cs_p    [NumDut] = '{1'b1, 1'b1};
    logic       busy_p  [NumDut] = '{1'b0, 1'b0};
    logic       sen_p   [NumDut] = '{1'b0, 1'b0};
    logic       clr_p   [NumDut] = '{1'b1, 1'b1};
    logic       mosi_p  [NumDut] = '{1'b0, 1'b0};
    logic       abort_p [NumDut] = '{1'b0, 1'b0};
    int         low_cnt [NumDut] = '{0, 0};
    int         hi_cnt  [NumDut] = '{1000, 1000};
    int         nbits   [NumDut] = '{0, 0};
    logic [7:0] rx      [NumDut] = '{8'h00, 8'h00};

    initial begin : monitor
        exp_t e;
        bit   have;
        int   div;
        forever begin
            @(negedge baseClk);
            for (int g = 0; g < NumDut; g++) begin
                div = div_of(g);
                // clr_p/sen_p hold what the DUT sampled on the rising edge just passed.
                if (clr_p[g] === 1'b1)
                    chk(busy[g] === 1'b0 && sck[g] === 1'b0 && cs_n[g] === 1'b1 &&
                        mosi[g] === 1'b0, "reset_outputs", g,
                        int'({busy[g], sck[g], cs_n[g], mosi[g]}), 2);
                if (cs_n[g] === 1'b1)
                    chk(sck[g] === 1'b0, "sck_idle_low", g, int'(sck[g]), 0);
                else
                    chk(busy[g] === 1'b1, "busy_in_frame", g, int'(busy[g]), 1);
                if (busy_p[g] === 1'b1 && busy[g] === 1'b0 && clr_p[g] !== 1'b1)
                    chk(sen_p[g] === 1'b0, "busy_drop_with_enable", g, int'(sen_p[g]), 0);

                if (cs_p[g] === 1'b1 && cs_n[g] === 1'b0) begin
                    if (!abort_p[g])
                        chk(hi_cnt[g] >= div + 1, "cs_high_gap", g, hi_cnt[g], div + 1);
                    low_cnt[g] = 1;
                    nbits[g]   = 0;
                    rx[g]      = '0;
                end else if (cs_n[g] === 1'b0) begin
                    low_cnt[g]++;
                end

                if (cs_n[g] === 1'b0 && sck_p[g] === 1'b0 && sck[g] === 1'b1) begin
                    chk(low_cnt[g] == div + 1 + 2 * div * nbits[g], "sck_rise_time", g,
                        low_cnt[g], div + 1 + 2 * div * nbits[g]);
                    chk(mosi[g] === mosi_p[g], "mosi_stable", g, int'(mosi[g]),
                        int'(mosi_p[g]));
                    chk(nbits[g] < 8, "extra_sck_rise", g, nbits[g] + 1, 8);
                    rx[g] = {rx[g][6:0], mosi[g]};
                    nbits[g]++;
                end

                if (cs_p[g] === 1'b0 && cs_n[g] === 1'b1) begin
                    have = 1'b0;
                    e    = '0;
                    if (g == 0 && exp_q0.size() > 0) begin
                        e    = exp_q0.pop_front();
                        have = 1'b1;
                    end else if (g == 1 && exp_q1.size() > 0) begin
                        e    = exp_q1.pop_front();
                        have = 1'b1;
                    end
                    chk(have, "unexpected_frame", g, int'(rx[g]), 0);
                    if (have && e.aborted) begin
                        chk(nbits[g] == 3, "abort_bit_count", g, nbits[g], 3);
                    end else if (have) begin
                        chk(nbits[g] == 8, "bit_count", g, nbits[g], 8);
                        chk(rx[g] == e.pat, "rx_byte", g, int'(rx[g]), int'(e.pat));
                        chk(low_cnt[g] == 17 * div, "cs_low_cycles", g, low_cnt[g], 17 * div);
                        chk(busy[g] === 1'b1, "busy_at_cs_rise", g, int'(busy[g]), 1);
                    end
                    hi_cnt[g]  = 1;
                    abort_p[g] = have && e.aborted;
                end else if (cs_n[g] === 1'b1) begin
                    hi_cnt[g]++;
                end

                sck_p[g]  = sck[g];
                cs_p[g]   = cs_n[g];
                busy_p[g] = busy[g];
                sen_p[g]  = sen[g];
                clr_p[g]  = clr[g];
                mosi_p[g] = mosi[g];
            end

            if (done_req) begin
                chk(exp_q0.size() == 0, "frames_missing", 0, exp_q0.size(), 0);
                chk(exp_q1.size() == 0, "frames_missing", 1, exp_q1.size(), 0);
                $display("Simulation finished: %0d checks, %0d errors", checks, errors);
                $finish;
            end
        end
    end

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog: simulation did not complete, %0d checks, %0d errors",
                 checks, errors);
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/spi_byte_tx.md
SPI_BYTE_TX -- requirements
Module: spi_byte_tx

Interface
REQ-001 The module SHALL have parameter CLK_DIV, default 4, giving baseClk cycles per spi_sck half-period (legal range 1..255).
REQ-002 The module SHALL have port baseClk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-003 The module SHALL have port hard_Clr, input, 1 bit: synchronous, active-high reset.
REQ-004 The module SHALL have port data, input, 8 bits: the byte to transmit, valid while sendEnable is high.
REQ-005 The module SHALL have port sendEnable, input, 1 bit: upstream transmit request, held high until sendBusy is seen high.
REQ-006 The module SHALL have port sendBusy, output, 1 bit: high while a byte is being accepted, shifted or retired.
REQ-007 The module SHALL have port spi_sck, output, 1 bit: the SPI clock, mode 0, idle low.
REQ-008 The module SHALL have port spi_cs_n, output, 1 bit: the active-low chip select, low only during a byte.
REQ-009 The module SHALL have port spi_mosi, output, 1 bit: serial data, stable across each spi_sck rising edge.

Function
REQ-010 The module SHALL implement four states, IDLE, SETUP, SHIFT and DONE, with every output registered.
REQ-011 In IDLE, when sendEnable=1 is sampled, the module SHALL on that edge capture data into an 8-bit shift register, set sendBusy=1 and spi_cs_n=0, drive spi_mosi with the first bit, and enter SETUP.
REQ-012 The module SHALL hold SETUP for CLK_DIV cycles, then enter SHIFT and drive spi_sck high.
REQ-013 In SHIFT, spi_sck SHALL toggle every CLK_DIV cycles, using an 8-bit half-period counter and a 3-bit bit counter.
REQ-014 On each spi_sck falling edge except the 8th, spi_mosi SHALL advance to the next bit.
REQ-015 After the 8th spi_sck falling edge, the module SHALL enter DONE with spi_sck=0 held for CLK_DIV cycles, then drive spi_cs_n=1.
REQ-016 From SETUP entry to spi_cs_n rising SHALL be 17*CLK_DIV cycles.
REQ-017 In DONE, once spi_cs_n=1 and sendEnable=0 are sampled, sendBusy SHALL go 0 on that edge and the module SHALL enter IDLE.
REQ-018 While sendEnable stays high in DONE, the module SHALL keep sendBusy=1, so one request never produces two bytes.
REQ-019 The module SHALL ignore sendEnable and data in every state except IDLE.
REQ-020 With CLK_DIV=1, spi_sck SHALL toggle every cycle, the byte SHALL take 17 cycles, and no state SHALL be skipped.
REQ-021 Back-to-back bytes SHALL be separated by at least CLK_DIV cycles of spi_cs_n=1 plus one IDLE cycle.

Reset
REQ-022 On a baseClk edge with hard_Clr=1, the module SHALL force IDLE, sendBusy=0, spi_sck=0, spi_cs_n=1 and spi_mosi=0, and clear all counters and the shift register.
REQ-023 hard_Clr asserted mid-byte SHALL abort the byte with no further spi_sck edges.
REQ-024 After hard_Clr deasserts, the next sampled sendEnable=1 SHALL start a fresh byte.
REQ-025 hard_Clr SHALL take priority over every other input.

Configuration
REQ-026 With macro SPI_LSB_FIRST_EN defined, bits SHALL be shifted out LSB first (data[0] first).
REQ-027 With SPI_LSB_FIRST_EN undefined (the default), bits SHALL be shifted out MSB first (data[7] first).
REQ-028 The macro SHALL affect only bit order, not timing or handshake.

Verification
REQ-029 CLK_DIV=4, data=0xA5 with sendEnable pulsed high until sendBusy=1 -> 8 spi_sck rising edges sample 1,0,1,0,0,1,0,1; spi_cs_n is low for exactly 68 cycles; sendBusy then returns to 0.
REQ-030 Upstream frame 0xFF, 0x78, 0x56, 0x34, 0x12 sent through the handshake -> the bench SPI slave receives exactly those 5 bytes in order, with no duplicates.
REQ-031 sendEnable held high through the whole byte -> sendBusy stays 1 after spi_cs_n rises until sendEnable drops, and exactly one byte is sent.
REQ-032 hard_Clr pulsed for 1 cycle after the 3rd spi_sck rising edge -> on the next edge spi_cs_n=1, spi_sck=0 and sendBusy=0; no further spi_sck edges occur.
REQ-033 CLK_DIV=1 with data=0x3C -> spi_sck period is 2 cycles; the slave receives 0x3C; spi_cs_n is low for 17 cycles.
REQ-034 With SPI_LSB_FIRST_EN defined and data=0x01 -> the first spi_sck rising edge samples 1 and the remaining 7 edges sample 0.
